// File: rtl/writeback_buffered_pkg.sv
// Shared definitions for the buffered writeback stage: op-flag encodings
// ({ld,cmp,alu}) and the layout of one buffered entry.
package writeback_buffered_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_ALU  = 3'b001,
        OP_CMP  = 3'b010,
        OP_ALUS = 3'b011,
        OP_LD   = 3'b100
    } op_e;

    // Entry layout, MSB first: {wr_rd, wr_cpsr, rd_num, data, cpsr}
    function automatic int unsigned entry_width(int unsigned rn_w, int unsigned data_w);
        return 2 + rn_w + 2 * data_w;
    endfunction

    function automatic int unsigned data_lsb(int unsigned data_w);
        return data_w;
    endfunction

    function automatic int unsigned rn_lsb(int unsigned data_w);
        return 2 * data_w;
    endfunction

endpackage

// File: rtl/writeback_buffered_fifo.sv
// Circular entry buffer with push/pop/flush; exposes entries in age order
// (slot 0 = head) with a matching valid mask for the forwarding search.
module wb_entry_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned FILL_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [FILL_W-1:0]      count,
    output logic                   empty,
    output logic [WIDTH-1:0]       head,
    output logic [DEPTH*WIDTH-1:0] entries,
    output logic [DEPTH-1:0]       valid_mask
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign push_ok = push && (32'(count) < DEPTH);
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= bump(wr_ptr);
            if (pop_ok)  rd_ptr <= bump(rd_ptr);
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (!push_ok && pop_ok) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= push_data;
    end

    // Rotate physical slots into age order so the consumer need not know the pointers
    always_comb begin
        int unsigned idx;
        entries    = '0;
        valid_mask = '0;
        idx        = 0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = 32'(rd_ptr) + k;
            if (idx >= DEPTH) idx = idx - DEPTH;
            entries[k*WIDTH +: WIDTH] = mem[idx[PTR_W-1:0]];
            valid_mask[k]             = (k < 32'(count));
        end
    end

endmodule

// File: rtl/writeback_buffered.sv
// Buffered writeback stage: decodes retiring MEM results into an in-order
// buffer, drives one RF/CPSR write per cycle, forwards and counts retirements.
module writeback_buffered
    import writeback_buffered_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned REG_N          = 16,
    parameter int unsigned DEPTH          = 2,
    parameter int unsigned ZERO_REG_WIRED = 0,
    parameter int unsigned CNT_W          = 16,
    localparam int unsigned RN_W          = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RN_W-1:0]   in_rd_num,
    input  logic [DATA_W-1:0] in_result,
    input  logic [DATA_W-1:0] in_dmem_val,
    input  logic [DATA_W-1:0] in_cpsr,
    input  logic              in_is_alu,
    input  logic              in_is_cmp,
    input  logic              in_is_ld,
    input  logic              flush,
    input  logic              rf_ready,
    output logic              rd_write_en,
    output logic [RN_W-1:0]   rd_num,
    output logic [DATA_W-1:0] rd_val,
    output logic              cpsr_write_en,
    output logic [DATA_W-1:0] cpsr_out,
    input  logic [RN_W-1:0]   fwd_req_num,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_val,
    output logic [CNT_W-1:0]  retire_count,
    output logic              err
);

    localparam int unsigned ENTRY_W  = entry_width(RN_W, DATA_W);
    localparam int unsigned DATA_LSB = data_lsb(DATA_W);
    localparam int unsigned RN_LSB   = rn_lsb(DATA_W);
    localparam int unsigned WRC_BIT  = RN_LSB + RN_W;
    localparam int unsigned WRR_BIT  = WRC_BIT + 1;
    localparam int unsigned FILL_W   = $clog2(DEPTH + 1);

    op_e                    op;
    logic                   dec_wr_rd;
    logic                   dec_wr_cpsr;
    logic                   dec_illegal;
    logic [DATA_W-1:0]      dec_data;
    logic                   accept;
    logic                   push;
    logic                   pop;
    logic [FILL_W-1:0]      fill;
    logic                   empty;
    logic [ENTRY_W-1:0]     head;
    logic [DEPTH*ENTRY_W-1:0] entries;
    logic [DEPTH-1:0]       valid_mask;
    logic [RN_W-1:0]        head_rn;
    logic [RN_W-1:0]        hold_rn;
    logic [DATA_W-1:0]      hold_val;
    logic [DATA_W-1:0]      hold_cpsr;

    always_comb begin
        op          = op_e'({in_is_ld, in_is_cmp, in_is_alu});
        dec_wr_rd   = 1'b0;
        dec_wr_cpsr = 1'b0;
        dec_illegal = 1'b0;
        dec_data    = in_result;
        case (op)
            OP_NOP:  ;
            OP_ALU:  dec_wr_rd = 1'b1;
            OP_CMP:  dec_wr_cpsr = 1'b1;
            OP_ALUS: begin
                dec_wr_rd   = 1'b1;
                dec_wr_cpsr = 1'b1;
            end
            OP_LD: begin
                dec_wr_rd = 1'b1;
                dec_data  = in_dmem_val;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign in_ready = (32'(fill) < DEPTH);
    assign accept   = in_valid && in_ready;
    assign push     = accept && (dec_wr_rd || dec_wr_cpsr);
    assign pop      = !empty && rf_ready;

    wb_entry_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_data  ({dec_wr_rd, dec_wr_cpsr, in_rd_num, dec_data, in_cpsr}),
        .pop        (pop),
        .flush      (flush),
        .count      (fill),
        .empty      (empty),
        .head       (head),
        .entries    (entries),
        .valid_mask (valid_mask)
    );

    // Data outputs fall back to the last presented head while the buffer is empty
    assign head_rn       = head[RN_LSB +: RN_W];
    assign rd_write_en   = !empty && head[WRR_BIT] && !((ZERO_REG_WIRED != 0) && (head_rn == '0));
    assign cpsr_write_en = !empty && head[WRC_BIT];
    assign rd_num        = empty ? hold_rn   : head_rn;
    assign rd_val        = empty ? hold_val  : head[DATA_LSB +: DATA_W];
    assign cpsr_out      = empty ? hold_cpsr : head[DATA_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_rn      <= '0;
            hold_val     <= '0;
            hold_cpsr    <= '0;
            retire_count <= '0;
            err          <= 1'b0;
        end else begin
            if (!empty) begin
                hold_rn   <= head_rn;
                hold_val  <= head[DATA_LSB +: DATA_W];
                hold_cpsr <= head[DATA_W-1:0];
            end
            if (pop && !flush) retire_count <= retire_count + 1'b1;
            if (accept && dec_illegal) err <= 1'b1;
        end
    end

    // Oldest to newest; a later match overrides, so the youngest writer wins
    always_comb begin
        fwd_hit = 1'b0;
        fwd_val = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (valid_mask[k] && entries[k*ENTRY_W + WRR_BIT]
                && (entries[k*ENTRY_W + RN_LSB +: RN_W] == fwd_req_num)) begin
                fwd_hit = 1'b1;
                fwd_val = entries[k*ENTRY_W + DATA_LSB +: DATA_W];
            end
        end
    end

endmodule
